// File: rtl/change_dispenser.sv
// Change dispenser: drives the soda motor, then pays change greedily (dimes first)
// one coin per valid/ready handshake, stalling in FAULT when inventory runs short.
module change_dispenser #(
  parameter int CNT_W       = 4,
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             soda_i,
  input  logic [2:0]       change_i,
  output logic             vend_o,
  input  logic             vend_ack_i,
  output logic             coin_valid_o,
  output logic             coin_dime_o,
  input  logic             coin_ready_i,
  input  logic             refill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] nickel_cnt_o,
  output logic [CNT_W-1:0] dime_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t           state_q;
  logic [2:0]       rem_q;
  logic [CNT_W-1:0] nickel_q;
  logic [CNT_W-1:0] dime_q;
  logic             vend_q;
  logic             coin_valid_q;
  logic             coin_dime_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic             illegal_q;

  logic [1:0]       pick_d;
  logic [2:0]       rem_after_d;
  logic             xfer_d;

  // Returns {coin available, coin is a dime}; dimes take priority when rem >= 2.
  function automatic logic [1:0] pick_coin(input logic [2:0]       rem,
                                           input logic [CNT_W-1:0] nickels,
                                           input logic [CNT_W-1:0] dimes);
    if (rem >= 3'd2 && dimes != '0) return 2'b11;
    if (rem != 3'd0 && nickels != '0) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    pick_d      = pick_coin(rem_q, nickel_q, dime_q);
    xfer_d      = coin_valid_q && coin_ready_i;
    rem_after_d = rem_q - (coin_dime_q ? 3'd2 : 3'd1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rem_q        <= 3'd0;
      nickel_q     <= CNT_W'(NICKEL_INIT);
      dime_q       <= CNT_W'(DIME_INIT);
      vend_q       <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_dime_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (refill_i) begin
            nickel_q <= CNT_W'(NICKEL_INIT);
            dime_q   <= CNT_W'(DIME_INIT);
          end
          if (soda_i) begin
            if (change_i > 3'd4) begin
              rem_q     <= 3'd0;
              illegal_q <= 1'b1;
            end else begin
              rem_q <= change_i;
            end
            state_q <= S_VEND;
            vend_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        S_VEND: begin
          if (vend_ack_i) begin
            vend_q <= 1'b0;
            if (rem_q == 3'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (pick_d[1]) begin
              state_q      <= S_CHANGE;
              coin_valid_q <= 1'b1;
              coin_dime_q  <= pick_d[0];
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end
        end

        // coin_valid_q low in this state is the one-cycle gap between coins,
        // where the next coin is chosen from the already-updated inventory.
        S_CHANGE: begin
          if (coin_valid_q) begin
            if (xfer_d) begin
              if (coin_dime_q) begin
                if (dime_q != '0) dime_q <= dime_q - CNT_W'(1);
              end else begin
                if (nickel_q != '0) nickel_q <= nickel_q - CNT_W'(1);
              end
              rem_q        <= rem_after_d;
              coin_valid_q <= 1'b0;
              coin_dime_q  <= 1'b0;
              if (rem_after_d == 3'd0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end else if (pick_d[1]) begin
            coin_valid_q <= 1'b1;
            coin_dime_q  <= pick_d[0];
          end else begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        S_FAULT: begin
          if (refill_i) begin
            nickel_q <= CNT_W'(NICKEL_INIT);
            dime_q   <= CNT_W'(DIME_INIT);
            fault_q  <= 1'b0;
            state_q  <= S_CHANGE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          vend_q       <= 1'b0;
          coin_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          fault_q      <= 1'b0;
        end
      endcase
    end
  end

  assign vend_o       = vend_q;
  assign coin_valid_o = coin_valid_q;
  assign coin_dime_o  = coin_dime_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;
  assign illegal_o    = illegal_q;
  assign nickel_cnt_o = nickel_q;
  assign dime_cnt_o   = dime_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: three instances share stimulus, each with
// different inventory sizes so exhaustion and fault/recovery can be exercised.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soda = 1'b0;
  logic [2:0] change = 3'd0;
  logic       ack = 1'b0;
  logic       ready = 1'b0;
  logic       refill = 1'b0;

  // standard 8/8 instance
  logic       s_vend, s_valid, s_dime, s_busy, s_done, s_fault, s_ill;
  logic [3:0] s_ncnt, s_dcnt;
  // one dime only
  logic       x_vend, x_valid, x_dime, x_busy, x_done, x_fault, x_ill;
  logic [3:0] x_ncnt, x_dcnt;
  // one nickel, no dimes
  logic       f_vend, f_valid, f_dime, f_busy, f_done, f_fault, f_ill;
  logic [3:0] f_ncnt, f_dcnt;

  int total = 0;
  int bad   = 0;
  int done_seen;
  int valid_seen;

  always #5 clk = ~clk;

  change_dispenser #(.CNT_W(4), .NICKEL_INIT(8), .DIME_INIT(8)) u_std (
    .clk_i(clk), .rst_i(rst), .soda_i(soda), .change_i(change),
    .vend_o(s_vend), .vend_ack_i(ack), .coin_valid_o(s_valid), .coin_dime_o(s_dime),
    .coin_ready_i(ready), .refill_i(refill), .busy_o(s_busy), .done_o(s_done),
    .fault_o(s_fault), .illegal_o(s_ill), .nickel_cnt_o(s_ncnt), .dime_cnt_o(s_dcnt)
  );

  change_dispenser #(.CNT_W(4), .NICKEL_INIT(8), .DIME_INIT(1)) u_dx (
    .clk_i(clk), .rst_i(rst), .soda_i(soda), .change_i(change),
    .vend_o(x_vend), .vend_ack_i(ack), .coin_valid_o(x_valid), .coin_dime_o(x_dime),
    .coin_ready_i(ready), .refill_i(refill), .busy_o(x_busy), .done_o(x_done),
    .fault_o(x_fault), .illegal_o(x_ill), .nickel_cnt_o(x_ncnt), .dime_cnt_o(x_dcnt)
  );

  change_dispenser #(.CNT_W(4), .NICKEL_INIT(1), .DIME_INIT(0)) u_nf (
    .clk_i(clk), .rst_i(rst), .soda_i(soda), .change_i(change),
    .vend_o(f_vend), .vend_ack_i(ack), .coin_valid_o(f_valid), .coin_dime_o(f_dime),
    .coin_ready_i(ready), .refill_i(refill), .busy_o(f_busy), .done_o(f_done),
    .fault_o(f_fault), .illegal_o(f_ill), .nickel_cnt_o(f_ncnt), .dime_cnt_o(f_dcnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge(s).
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; soda = 1'b0; change = 3'd0; ack = 1'b0; ready = 1'b0; refill = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state
    do_reset();
    chk("rst_std_flags", {s_vend, s_valid, s_dime, s_busy, s_done, s_fault, s_ill}, 0);
    chk("rst_std_cnts", {s_ncnt, s_dcnt}, 8'h88);
    chk("rst_dx_flags", {x_vend, x_valid, x_dime, x_busy, x_done, x_fault, x_ill}, 0);
    chk("rst_dx_cnts", {x_ncnt, x_dcnt}, 8'h81);
    chk("rst_nf_flags", {f_vend, f_valid, f_dime, f_busy, f_done, f_fault, f_ill}, 0);
    chk("rst_nf_cnts", {f_ncnt, f_dcnt}, 8'h10);

    // ---------------- exact pay, ack tied high
    soda = 1'b1; change = 3'd0; ack = 1'b1;
    step(1);
    soda = 1'b0;
    chk("exact_vend_on", s_vend, 1);
    chk("exact_busy", s_busy, 1);
    step(1);
    chk("exact_vend_off", s_vend, 0);
    done_seen = 0; valid_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_done) done_seen++;
      if (s_valid) valid_seen++;
      step(1);
    end
    chk("exact_done_once", done_seen, 1);
    chk("exact_no_coin", valid_seen, 0);
    chk("exact_idle", s_busy, 0);
    chk("exact_cnts", {s_ncnt, s_dcnt}, 8'h88);

    // ---------------- 15c change, vend ack delayed two cycles
    do_reset();
    soda = 1'b1; change = 3'd3; ack = 1'b0; ready = 1'b1;
    step(1);
    soda = 1'b0;
    step(1);
    chk("c15_vend_held", {s_vend, s_valid}, 2'b10);
    ack = 1'b1;
    step(1);
    chk("c15_first_dime", {s_vend, s_valid, s_dime}, 3'b011);
    step(1);
    chk("c15_gap", s_valid, 0);
    chk("c15_dcnt", s_dcnt, 7);
    step(1);
    chk("c15_nickel", {s_valid, s_dime}, 2'b10);
    step(1);
    chk("c15_done", {s_done, s_valid}, 2'b10);
    chk("c15_cnts", {s_ncnt, s_dcnt}, 8'h77);
    step(1);
    chk("c15_end", {s_done, s_busy}, 2'b00);

    // ---------------- backpressure on 20c, stray soda and refill while busy
    do_reset();
    soda = 1'b1; change = 3'd4; ack = 1'b1; ready = 1'b0;
    step(1);
    soda = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable", {s_valid, s_dime}, 2'b11);
      soda = (i == 2); change = 3'd1;
      step(1);
    end
    soda = 1'b0;
    ready = 1'b1;
    step(1);
    chk("bp_gap", {s_valid, s_dcnt}, 5'h07);
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    chk("bp_second_dime", {s_valid, s_dime}, 2'b11);
    step(1);
    chk("bp_done", s_done, 1);
    chk("bp_cnts", {s_ncnt, s_dcnt}, 8'h86);

    // ---------------- dime exhaustion (one dime, 20c owed)
    do_reset();
    soda = 1'b1; change = 3'd4; ack = 1'b1; ready = 1'b1;
    step(1);
    soda = 1'b0;
    step(1);
    chk("dx_dime", {x_valid, x_dime}, 2'b11);
    step(1);
    chk("dx_gap", {x_valid, x_dcnt}, 5'h00);
    step(1);
    chk("dx_nickel1", {x_valid, x_dime}, 2'b10);
    step(2);
    chk("dx_nickel2", {x_valid, x_dime}, 2'b10);
    step(1);
    chk("dx_done", x_done, 1);
    chk("dx_cnts", {x_ncnt, x_dcnt}, 8'h60);

    // ---------------- fault and recovery: drain the only nickel, then owe 5c
    do_reset();
    soda = 1'b1; change = 3'd1; ack = 1'b1; ready = 1'b1;
    step(1);
    soda = 1'b0;
    step(1);
    chk("nf_first_nickel", {f_valid, f_dime}, 2'b10);
    step(2);
    chk("nf_drained", {f_busy, f_ncnt}, 5'h00);
    soda = 1'b1; change = 3'd1;
    step(1);
    soda = 1'b0;
    step(1);
    chk("nf_fault", {f_fault, f_valid, f_busy}, 3'b101);
    step(2);
    chk("nf_fault_held", {f_fault, f_valid, f_ncnt}, 6'b100000);
    refill = 1'b1;
    step(1);
    refill = 1'b0;
    chk("nf_refill", {f_fault, f_ncnt}, 5'h01);
    valid_seen = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (f_valid && !f_dime) valid_seen++;
      if (f_done) done_seen++;
      step(1);
    end
    chk("nf_paid_one", valid_seen, 1);
    chk("nf_done_once", done_seen, 1);
    chk("nf_final", {f_fault, f_busy, f_ncnt}, 6'h00);

    // ---------------- illegal code, then reset during a pending coin
    do_reset();
    soda = 1'b1; change = 3'd6; ack = 1'b1; ready = 1'b1;
    step(1);
    soda = 1'b0;
    chk("ill_flag", s_ill, 1);
    valid_seen = 0; done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_valid) valid_seen++;
      if (s_done) done_seen++;
      step(1);
    end
    chk("ill_no_coin", valid_seen, 0);
    chk("ill_done_once", done_seen, 1);
    chk("ill_sticky_cnts", {s_ill, s_ncnt, s_dcnt}, 9'h188);
    soda = 1'b1; change = 3'd2; ready = 1'b0;
    step(1);
    soda = 1'b0;
    step(1);
    chk("rst_pre_valid", {s_valid, s_dime, s_busy}, 3'b111);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_mid_flags", {s_vend, s_valid, s_dime, s_busy, s_done, s_fault, s_ill}, 0);
    chk("rst_mid_cnts", {s_ncnt, s_dcnt}, 8'h88);
    step(2);
    chk("rst_mid_stays_idle", {s_valid, s_busy}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
